fdct4x4_stream: RTL
===================

Name: fdct4x4_stream

Overview:
- Forward 2-D 4x4 integer DCT; the encoder-side counterpart of the team's 4x4 IDCT pipeline.
- Accepts one residual row (4 samples) per valid cycle and applies a row 1-D DCT with shift SHIFT1.
- Stores row results in a ping-pong transpose buffer, then applies a column 1-D DCT with shift SHIFT2.
- Emits one coefficient column per cycle in the 4-wide, 25-bit format the IDCT consumes.

Parameters:
- IN_W, 9, signed input sample width
- MID_W, 16, signed width of stored row-stage results (sign-truncated after shift)
- OUT_W, 25, signed output coefficient width
- SHIFT1, 1, row-stage right shift
- SHIFT2, 8, column-stage right shift

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  row present on in_0..in_3 this cycle
- in_first  in  1  qualifies in_valid; marks row 0 of a block
- in_0..in_3  in  IN_W each  row samples x[r][0..3], signed
- out_valid  out  1  out_0..out_3 hold a coefficient column
- out_last  out  1  high with column 3 of a block
- out_0..out_3  out  OUT_W each  Y[0..3][k] for column k, signed

Behaviour:
- Clock and reset: reset is asynchronous, active-high; clock is clk. On reset, row counter=0, write bank=0, both banks marked empty, read engine idle, out_valid=0, out_last=0, out_0..3=0.
- 1-D kernel (both stages): E0=a0+a3, E1=a1+a2, O0=a0-a3, O1=a1-a2; y0=64(E0+E1), y1=83*O0+36*O1, y2=64(E0-E1), y3=36*O0-83*O1. Arithmetic uses full internal precision.
- Stage shifts: rounding per the optional feature, then arithmetic (floor) right shift. Stage 1 is sign-truncated to MID_W; stage 2 is sign-extended to OUT_W.
- Row stage: at each edge with in_valid=1, the kernel result of the row is written into the write bank at index row_cnt, and row_cnt increments.
- Bank completion: when row_cnt=3 is written, the bank is marked full, row_cnt wraps to 0, and the write bank toggles.
- in_valid=0: nothing is written and row_cnt holds. Gaps of any length are allowed mid-block.
- in_first=1 with in_valid=1: the row is written as row 0 regardless of row_cnt, and row_cnt becomes 1. Partial rows of an abandoned block are discarded.
- in_first=0 while row_cnt=0: accepted as row 0, with no error.
- Read engine: starts on the edge after a bank becomes full. It then reads columns k=0..3 on 4 consecutive cycles. Each cycle it runs the kernel on Z[0..3][k] and registers the results into out_0..3, with out_valid=1.
- out_last: 1 on k=3. After k=3 the bank is marked empty.
- Latency: the first column is registered at the edge following the edge that accepted row 3. out_valid is therefore high from 1 cycle after the last row.
- Back-to-back blocks at the full rate of 1 row/cycle produce continuous out_valid with no bubble.
- Overrun cannot occur: a block takes at least 4 input cycles and readout takes exactly 4. No backpressure exists.
- Outputs hold their last values when out_valid=0.
- Reset mid-operation: any partial block and any in-flight readout are dropped, and out_valid=0 on the cycle after reset asserts.

Optional Feature:
- Macro: FDCT_ROUND_EN.
- Defined: add 1<<(SHIFT-1) before each stage's shift (round-half-up).
- Undefined: plain arithmetic shift (floor). All Test Plan values assume the macro is defined.

Test Plan:
- Flat block: all x=10, 4 rows back-to-back → column 0 = 1280,0,0,0; columns 1..3 all 0; out_valid high 4 cycles starting 1 cycle after row 3; out_last on the 4th.
- Negative flat block: all x=-10 → Y[0][0]=-1280, all others 0. This checks floor shift on negatives.
- Impulse block: x[0][0]=64, others 0 → column 0 = 512,664,512,288. Row stage must produce Z[0][*]=2048,2656,2048,1152.
- Gapped input: flat block with 3 idle cycles between each row → identical outputs, first out_valid exactly 1 cycle after row 3. Then two flat blocks back-to-back → 8 consecutive out_valid cycles and out_last on the 4th and 8th.
- Resync: 2 rows of x=50, then in_first with a flat x=10 block → only 1280,0,0,0 / zero columns are emitted; no output for the abandoned rows.
- Reset mid-readout: assert reset during column 1 → out_valid=0, outputs 0. After release, a new flat block gives correct results starting from column 0.

Source files
------------

// File: rtl/fdct4x4_stream.sv
// Streaming forward 4x4 integer DCT: row kernel -> ping-pong transpose bank -> column kernel.
// Define FDCT_ROUND_EN to add round-half-up before each stage shift; default build uses floor shifts.
//
// state  | meaning
// S_IDLE | no readout in flight; starts one when the next bank to read is full
// S_READ | emitting columns 1..3 of the bank at r_rd_bank
module fdct4x4_stream #(
    parameter int IN_W   = 9,
    parameter int MID_W  = 16,
    parameter int OUT_W  = 25,
    parameter int SHIFT1 = 1,
    parameter int SHIFT2 = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    input  logic                    in_first,
    input  logic signed [IN_W-1:0]  in_0,
    input  logic signed [IN_W-1:0]  in_1,
    input  logic signed [IN_W-1:0]  in_2,
    input  logic signed [IN_W-1:0]  in_3,
    output logic                    out_valid,
    output logic                    out_last,
    output logic signed [OUT_W-1:0] out_0,
    output logic signed [OUT_W-1:0] out_1,
    output logic signed [OUT_W-1:0] out_2,
    output logic signed [OUT_W-1:0] out_3
);
    localparam int ACC_W = 40;
    typedef logic signed [ACC_W-1:0] acc_t;
    localparam acc_t C64 = 64;
    localparam acc_t C83 = 83;
    localparam acc_t C36 = 36;

    typedef enum logic {S_IDLE, S_READ} state_t;

    function automatic acc_t kern(input acc_t a0, input acc_t a1, input acc_t a2,
                                  input acc_t a3, input logic [1:0] idx);
        acc_t e0, e1, o0, o1;
        e0 = a0 + a3;
        e1 = a1 + a2;
        o0 = a0 - a3;
        o1 = a1 - a2;
        case (idx)
            2'd0:    return C64 * (e0 + e1);
            2'd1:    return C83 * o0 + C36 * o1;
            2'd2:    return C64 * (e0 - e1);
            default: return C36 * o0 - C83 * o1;
        endcase
    endfunction

    function automatic acc_t shr(input acc_t v, input int s);
`ifdef FDCT_ROUND_EN
        return (v + (acc_t'(1) <<< (s - 1))) >>> s;
`else
        return v >>> s;
`endif
    endfunction

    logic signed [MID_W-1:0] r_bank [2][4][4];
    logic [1:0]              r_row_cnt;
    logic                    r_wbank;
    logic [1:0]              r_full;
    logic                    r_rd_bank;
    logic [1:0]              r_col;
    state_t                  r_state;

    logic [1:0]              w_wrow;
    logic                    w_rd;
    logic [1:0]              w_col;
    logic signed [MID_W-1:0] w_z [4];
    logic signed [OUT_W-1:0] w_y [4];

    assign w_wrow = in_first ? 2'd0 : r_row_cnt;
    assign w_rd   = (r_state == S_READ) || r_full[r_rd_bank];
    assign w_col  = (r_state == S_READ) ? r_col : 2'd0;

    always_comb begin
        for (int u = 0; u < 4; u++) begin
            w_z[u] = MID_W'(shr(kern(acc_t'(in_0), acc_t'(in_1), acc_t'(in_2), acc_t'(in_3),
                                     2'(u)), SHIFT1));
        end
    end

    // Column k of the transpose bank is the row-stage output index k of each stored row.
    always_comb begin
        for (int v = 0; v < 4; v++) begin
            w_y[v] = OUT_W'(shr(kern(acc_t'(r_bank[r_rd_bank][0][w_col]),
                                     acc_t'(r_bank[r_rd_bank][1][w_col]),
                                     acc_t'(r_bank[r_rd_bank][2][w_col]),
                                     acc_t'(r_bank[r_rd_bank][3][w_col]), 2'(v)), SHIFT2));
        end
    end

    always_ff @(posedge clk) begin
        if (in_valid) begin
            for (int u = 0; u < 4; u++) begin
                r_bank[r_wbank][w_wrow][u] <= w_z[u];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_row_cnt <= 2'd0;
            r_wbank   <= 1'b0;
            r_full    <= 2'b00;
            r_rd_bank <= 1'b0;
            r_col     <= 2'd0;
            r_state   <= S_IDLE;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_0     <= '0;
            out_1     <= '0;
            out_2     <= '0;
            out_3     <= '0;
        end else begin
            out_valid <= w_rd;
            out_last  <= w_rd && (w_col == 2'd3);
            if (w_rd) begin
                out_0 <= w_y[0];
                out_1 <= w_y[1];
                out_2 <= w_y[2];
                out_3 <= w_y[3];
                if (w_col == 2'd3) begin
                    r_full[r_rd_bank] <= 1'b0;
                    r_rd_bank         <= ~r_rd_bank;
                    r_state           <= S_IDLE;
                end else begin
                    r_col   <= w_col + 2'd1;
                    r_state <= S_READ;
                end
            end
            // Placed after the readout clear so a same-cycle fill of the other bank is never lost.
            if (in_valid) begin
                if (w_wrow == 2'd3) begin
                    r_full[r_wbank] <= 1'b1;
                    r_wbank         <= ~r_wbank;
                    r_row_cnt       <= 2'd0;
                end else begin
                    r_row_cnt <= w_wrow + 2'd1;
                end
            end
        end
    end
endmodule
